// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// Round-robin arbitration in IDLE, one EXEC cycle to capture the ALU
// outputs, then a registered response held in RESP until rsp_ready.
// Optional per-requester grant counters: define ALU_ARB_STATS_EN.
module alu_arbiter #(
   parameter int N     = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [N-1:0]     req0_a,
   input  logic [N-1:0]     req0_b,
   input  logic [2:0]       req0_ctrl,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [N-1:0]     req1_a,
   input  logic [N-1:0]     req1_b,
   input  logic [2:0]       req1_ctrl,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [N-1:0]     rsp_result,
   output logic             rsp_fZ,
   output logic             rsp_id,
   output logic [N-1:0]     alu_a,
   output logic [N-1:0]     alu_b,
   output logic [2:0]       alu_ctrl,
   input  logic [N-1:0]     alu_result,
   input  logic             alu_fZ,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_next_state;
   logic         r_last_gnt;
   logic [N-1:0] r_op_a;
   logic [N-1:0] r_op_b;
   logic [2:0]   r_op_ctrl;
   logic         r_rsp_valid;
   logic [N-1:0] r_rsp_result;
   logic         r_rsp_fZ;
   logic         r_rsp_id;

   logic         w_gnt_valid;
   logic         w_gnt_id;
   logic         w_accept;
   logic [N-1:0] w_sel_a;
   logic [N-1:0] w_sel_b;
   logic [2:0]   w_sel_ctrl;

   // Round-robin grant: on contention the requester that did not win last time goes.
   always_comb begin
      w_gnt_valid = 1'b0;
      w_gnt_id    = 1'b0;
      if (req0_valid && req1_valid) begin
         w_gnt_valid = 1'b1;
         w_gnt_id    = ~r_last_gnt;
      end else if (req0_valid) begin
         w_gnt_valid = 1'b1;
         w_gnt_id    = 1'b0;
      end else if (req1_valid) begin
         w_gnt_valid = 1'b1;
         w_gnt_id    = 1'b1;
      end else begin
         w_gnt_valid = 1'b0;
         w_gnt_id    = 1'b0;
      end
   end

   assign w_accept   = (r_state == ST_IDLE) && w_gnt_valid;
   assign w_sel_a    = w_gnt_id ? req1_a    : req0_a;
   assign w_sel_b    = w_gnt_id ? req1_b    : req0_b;
   assign w_sel_ctrl = w_gnt_id ? req1_ctrl : req0_ctrl;

   // FSM state register; reset aborts any operation in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic: IDLE -> EXEC on handshake, EXEC -> RESP, RESP -> IDLE on rsp_ready.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_EXEC;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_EXEC: begin
            w_next_state = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // FSM outputs: only the granted requester sees ready, and only while IDLE.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      if (w_accept) begin
         req0_ready = ~w_gnt_id;
         req1_ready = w_gnt_id;
      end else begin
         req0_ready = 1'b0;
         req1_ready = 1'b0;
      end
   end

   // Operand, arbitration history and response registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_op_ctrl    <= 3'b000;
         r_last_gnt   <= 1'b1;
         r_rsp_valid  <= 1'b0;
         r_rsp_result <= '0;
         r_rsp_fZ     <= 1'b0;
         r_rsp_id     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_op_a     <= w_sel_a;
            r_op_b     <= w_sel_b;
            r_op_ctrl  <= w_sel_ctrl;
            r_rsp_id   <= w_gnt_id;
            r_last_gnt <= w_gnt_id;
         end
         if (r_state == ST_EXEC) begin
            r_rsp_result <= alu_result;
            r_rsp_fZ     <= alu_fZ;
            r_rsp_valid  <= 1'b1;
         end else if ((r_state == ST_RESP) && rsp_ready) begin
            r_rsp_valid  <= 1'b0;
         end
      end
   end

   assign alu_a      = r_op_a;
   assign alu_b      = r_op_b;
   assign alu_ctrl   = r_op_ctrl;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_result = r_rsp_result;
   assign rsp_fZ     = r_rsp_fZ;
   assign rsp_id     = r_rsp_id;

`ifdef ALU_ARB_STATS_EN
   logic [CNT_W-1:0] r_gnt_cnt0;
   logic [CNT_W-1:0] r_gnt_cnt1;

   // Per-requester grant counters, wrapping naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_gnt_cnt0 <= '0;
         r_gnt_cnt1 <= '0;
      end else if (w_accept) begin
         if (w_gnt_id) begin
            r_gnt_cnt1 <= r_gnt_cnt1 + {{(CNT_W-1){1'b0}}, 1'b1};
         end else begin
            r_gnt_cnt0 <= r_gnt_cnt0 + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign gnt_cnt0 = r_gnt_cnt0;
   assign gnt_cnt1 = r_gnt_cnt1;
`else
   assign gnt_cnt0 = '0;
   assign gnt_cnt1 = '0;
`endif

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational ALU (operands a/b, 3-bit alu_ctrl, result, fZ zero flag) between two requesters.
- Uses round-robin arbitration, a valid/ready request handshake per requester, and a single registered response channel tagged with the requester id.
- Sits between the ALU and its two clients, e.g. the main datapath and a co-processing unit. It drives the ALU inputs from registers and captures the ALU outputs into registers.

Parameters:
N, 32, operand/result width (matches ALU n)
CNT_W, 16, width of per-requester grant counters (optional feature)

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  N  requester 0 operand a
req0_b  input  N  requester 0 operand b
req0_ctrl  input  3  requester 0 ALU op code
req1_valid / req1_ready / req1_a / req1_b / req1_ctrl  same as requester 0, for requester 1
rsp_valid  output  1  response held valid
rsp_ready  input  1  consumer accepts response
rsp_result  output  N  captured ALU result
rsp_fZ  output  1  captured ALU zero flag
rsp_id  output  1  requester that issued the operation
alu_a  output  N  to ALU a
alu_b  output  N  to ALU b
alu_ctrl  output  3  to ALU alu_ctrl
alu_result  input  N  from ALU result
alu_fZ  input  1  from ALU fZ
gnt_cnt0  output  CNT_W  grants to requester 0 (optional feature)
gnt_cnt1  output  CNT_W  grants to requester 1 (optional feature)

Behaviour:
- Clocking and reset:
  - Single clock domain. All state updates on posedge clk.
  - Reset is synchronous, active-high and has priority over everything else.
  - Reset values: state=IDLE; op_a/op_b/op_ctrl=0, so alu_a=0, alu_b=0, alu_ctrl=0; rsp_valid=0, rsp_result=0, rsp_fZ=0, rsp_id=0; last_gnt=1; counters=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitration is combinational.
  - If both valid, grant the requester != last_gnt. If only one valid, grant it. If none valid, no grant.
  - reqX_ready = (state==IDLE) && grant==X. It is asserted for at most one requester, and only when that requester's valid is high.
  - On handshake (valid & ready): latch a/b/ctrl into op regs, set rsp_id=X and last_gnt=X, then go to EXEC.
- EXEC:
  - alu_a/alu_b/alu_ctrl are driven from op regs (they always are, in every state).
  - At the end of the cycle: latch alu_result into rsp_result and alu_fZ into rsp_fZ, set rsp_valid=1, go to RESP.
  - The ALU is purely combinational, so one cycle is sufficient.
- RESP:
  - rsp_valid=1. rsp_result, rsp_fZ and rsp_id are stable.
  - On rsp_ready=1: rsp_valid=0 and go to IDLE at that edge.
  - If rsp_ready is already high on entry, RESP lasts exactly one cycle.
  - No new request is accepted in EXEC or RESP; both readys are 0.
- Latency and throughput:
  - Handshake at edge T. rsp_valid is visible after edge T+1 (2 cycles from request to response).
  - Minimum 3 cycles per operation (IDLE, EXEC, RESP).
- Requester rules:
  - A requester may drop valid before ready without effect; nothing is latched.
  - Operands are sampled only on the handshake cycle.
- Op codes: passed through unmodified (000 add, 001 sub, 010 and, 011 or, 100 xor, 101 sll, 110 srl, 111 slt). No decoding or width changes in this block.
- Fairness: under continuous dual requests, grants strictly alternate. With last_gnt=1 after reset, requester 0 wins the first contention.
- Reset mid-operation: reset in EXEC or RESP aborts the operation. rsp_valid=0 next cycle and no response is ever produced for the aborted operation.

Optional Feature:
- Macro: ALU_ARB_STATS_EN.
- Defined:
  - gnt_cnt0 and gnt_cnt1 increment by 1 on each handshake of the respective requester.
  - Counters wrap modulo 2^CNT_W (0xFFFF+1 -> 0x0000 at default).
  - Reset clears them to 0.
- Undefined:
  - No counter registers exist.
  - gnt_cnt0 and gnt_cnt1 are tied to 0.
  - Port list is unchanged.

Test Plan:
1. Single req0 add: a=0x12345678, b=0x87654321, ctrl=000 -> req0_ready high in IDLE cycle. 2 cycles later rsp_valid=1, rsp_result=0x99999999, rsp_fZ=0, rsp_id=0.
2. Both valid, same cycle after reset: req0 sub 0x87654321-0x12345678, req1 and 0xabcdef00&0x00ff00ff, rsp_ready=1 -> req0 granted first (rsp 0x7530ECA9, id 0), then req1 (rsp 0x00cd0000, id 1). Grants alternate 0,1,0,1 for 4 further dual requests.
3. Zero flag: req1 sub a=b=5 -> rsp_result=0, rsp_fZ=1, rsp_id=1.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, req0 valid with xor throughout -> rsp_valid held, rsp_result stable; both readys stay 0; req0 accepted only in the IDLE cycle after rsp_ready=1. Expected xor result 0xab32efff.
5. Reset mid-op: assert reset during EXEC -> next cycle rsp_valid=0, alu_a=0, state IDLE. No response for the aborted op; a subsequent or op 0xabcdef00|0x00ff00ff returns 0xabffefff.
6. With ALU_ARB_STATS_EN: 3 req0 and 2 req1 grants -> gnt_cnt0=3, gnt_cnt1=2. Without the macro, both read 0.
